hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 16-bit five-stage CPU. It drives the write-enable and flush inputs of the IF/ID register, the PC write-enable, the ID/EX bubble and the back-end stage enables. It resolves four conditions:
- load-use hazards, by stalling and inserting a bubble;
- taken branches, by flushing IF/ID;
- data-memory wait states, by freezing the whole pipe;
- HLT, by draining the pipeline and then halting.

---
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 16-bit five-stage CPU.
// It handles load-use stalls, taken-branch flushes, data-memory freezes and the HLT drain/halt sequence.
module hazard_ctrl #(
  parameter logic [15:0] RS_MASK      = 16'h23FF,
  parameter logic [15:0] RT_MASK      = 16'h028F,
  parameter logic [3:0]  HALT_OP      = 4'hF,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      id_instr,
  input  logic             ex_memread,
  input  logic [3:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_stall,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_wen,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          cnt_inc;
  logic          pc_wen_c, ifid_wen_c, ifid_flush_c, idex_bubble_c, pipe_wen_c;

  logic [3:0] op, rs, rt;
  logic       lu;
  logic       unused_instr;

  assign op = id_instr[15:12];
  assign rs = id_instr[7:4];
  assign rt = id_instr[3:0];
  assign unused_instr = ^id_instr[11:8];

  // r0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign lu = ex_memread && (ex_rd != 4'd0) &&
              ((RS_MASK[op] && (rs == ex_rd)) || (RT_MASK[op] && (rt == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (cnt_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_nxt     = drain_cnt;
    cnt_inc       = 1'b0;
    pc_wen_c      = 1'b0;
    ifid_wen_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    pipe_wen_c    = 1'b0;
    case (state)
      ST_RUN: begin
        if (dmem_stall) begin
          cnt_inc = 1'b1;
        end else if (lu) begin
          idex_bubble_c = 1'b1;
          pipe_wen_c    = 1'b1;
          cnt_inc       = 1'b1;
        end else if (branch_taken) begin
          pc_wen_c     = 1'b1;
          ifid_wen_c   = 1'b1;
          ifid_flush_c = 1'b1;
          pipe_wen_c   = 1'b1;
        end else if (op == HALT_OP) begin
          idex_bubble_c = 1'b1;
          pipe_wen_c    = 1'b1;
          state_nxt     = ST_DRAIN;
          drain_nxt     = DRAIN_INIT;
        end else begin
          pc_wen_c   = 1'b1;
          ifid_wen_c = 1'b1;
          pipe_wen_c = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Front end is held; bubbles push the older instructions out the back.
        idex_bubble_c = 1'b1;
        pipe_wen_c    = !dmem_stall;
        if (!dmem_stall) begin
          drain_nxt = drain_cnt - DW'(1);
          if (drain_cnt == DW'(1))
            state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: ;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Gating with rst_n forces every control output low the instant reset asserts.
  assign pc_wen      = rst_n & pc_wen_c;
  assign ifid_wen    = rst_n & ifid_wen_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign idex_bubble = rst_n & idex_bubble_c;
  assign pipe_wen    = rst_n & pipe_wen_c;
  assign halted      = (state == ST_HALTED);
  assign dbg_state   = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a driver issues one vector per cycle and queues the expected outputs,
// and a negedge monitor pops and compares. A second instance with CNT_W=4 covers counter saturation.
module tb_hazard_ctrl;

  localparam int W = 28;

  // {pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_wen, halted}
  localparam logic [5:0] C_NORM = 6'b110010;
  localparam logic [5:0] C_FRZ  = 6'b000000;
  localparam logic [5:0] C_BUB  = 6'b000110;
  localparam logic [5:0] C_BR   = 6'b111010;
  localparam logic [5:0] C_DRS  = 6'b000100;
  localparam logic [5:0] C_HLT  = 6'b000001;

  localparam logic [1:0] S_RUN = 2'd0, S_DRN = 2'd1, S_HLT = 2'd2;

  localparam logic [15:0] I_NOP = 16'h1234;
  localparam logic [15:0] I_LU  = 16'h2130;
  localparam logic [15:0] I_HLT = 16'hF000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] id_instr = I_NOP;
  logic        ex_memread = 1'b0;
  logic [3:0]  ex_rd = 4'd0;
  logic        branch_taken = 1'b0;
  logic        dmem_stall = 1'b0;

  logic        pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_wen, halted;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  logic        s_pc_wen, s_ifid_wen, s_ifid_flush, s_idex_bubble, s_pipe_wen, s_halted;
  logic [3:0]  sat_cnt;
  logic [1:0]  s_dbg_state;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .dmem_stall(dmem_stall), .pc_wen(pc_wen), .ifid_wen(ifid_wen),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_wen(pipe_wen), .halted(halted),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .dmem_stall(dmem_stall), .pc_wen(s_pc_wen), .ifid_wen(s_ifid_wen),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .pipe_wen(s_pipe_wen), .halted(s_halted),
    .stall_cnt(sat_cnt), .dbg_state(s_dbg_state)
  );

  task automatic step(input logic rst, input logic [15:0] instr, input logic mr, input logic [3:0] rd,
                      input logic br, input logic dms, input logic [1:0] st, input logic [5:0] ctrl,
                      input logic [15:0] c16, input logic [3:0] c4, input string tag);
    @(posedge clk);
    #1;
    rst_n        = rst;
    id_instr     = instr;
    ex_memread   = mr;
    ex_rd        = rd;
    branch_taken = br;
    dmem_stall   = dms;
    exp_q.push_back({st, ctrl, c16, c4});
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e, got;
    string        t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {dbg_state, pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_wen, halted, stall_cnt, sat_cnt};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s @%0t: got=%h exp=%h (state,ctrl6,cnt16,cnt4)", t, $time, got, e);
      end
    end
  end

  initial begin
    step(0, I_NOP, 0, 0, 0, 0, S_RUN, C_FRZ,  0, 0, "reset");
    step(1, I_NOP, 0, 0, 0, 0, S_RUN, C_NORM, 0, 0, "run_after_reset");
    step(1, I_LU,  1, 3, 0, 0, S_RUN, C_BUB,  0, 0, "lu_rs");
    step(1, I_LU,  0, 3, 0, 0, S_RUN, C_NORM, 1, 1, "lu_resume");
    step(1, I_LU,  1, 0, 0, 0, S_RUN, C_NORM, 1, 1, "lu_r0");
    step(1, 16'hC055, 1, 5, 0, 0, S_RUN, C_NORM, 1, 1, "mask_opc");
    step(1, 16'h0015, 1, 5, 0, 0, S_RUN, C_BUB,  1, 1, "lu_rt");
    step(1, I_NOP, 0, 0, 0, 0, S_RUN, C_NORM, 2, 2, "lu_rt_resume");
    step(1, 16'h4015, 1, 5, 0, 0, S_RUN, C_NORM, 2, 2, "mask_rt_unused");
    step(1, I_NOP, 0, 0, 1, 0, S_RUN, C_BR,   2, 2, "branch");
    step(1, I_NOP, 0, 0, 1, 1, S_RUN, C_FRZ,  2, 2, "branch_frz1");
    step(1, I_NOP, 0, 0, 1, 1, S_RUN, C_FRZ,  3, 3, "branch_frz2");
    step(1, I_NOP, 0, 0, 1, 0, S_RUN, C_BR,   4, 4, "branch_after_frz");
    step(1, I_LU,  1, 3, 0, 1, S_RUN, C_FRZ,  4, 4, "lu_frz");
    step(1, I_LU,  1, 3, 0, 0, S_RUN, C_BUB,  5, 5, "lu_after_frz");
    step(1, I_NOP, 0, 0, 0, 0, S_RUN, C_NORM, 6, 6, "run");
    // HLT drain with no freeze
    step(1, I_HLT, 0, 0, 0, 0, S_RUN, C_BUB,  6, 6, "hlt_t");
    step(1, I_NOP, 0, 0, 1, 0, S_DRN, C_BUB,  6, 6, "drain1");
    step(1, I_LU,  1, 3, 0, 0, S_DRN, C_BUB,  6, 6, "drain2");
    step(1, I_NOP, 0, 0, 0, 0, S_DRN, C_BUB,  6, 6, "drain3");
    step(1, I_NOP, 0, 0, 0, 0, S_HLT, C_HLT,  6, 6, "halted_t4");
    step(1, I_NOP, 0, 0, 1, 0, S_HLT, C_HLT,  6, 6, "halted_hold");
    // HLT drain stretched by one freeze cycle
    step(0, I_NOP, 0, 0, 0, 0, S_RUN, C_FRZ,  0, 0, "reset_halted");
    step(1, I_NOP, 0, 0, 0, 0, S_RUN, C_NORM, 0, 0, "run2");
    step(1, I_HLT, 0, 0, 0, 0, S_RUN, C_BUB,  0, 0, "hlt2_t");
    step(1, I_NOP, 0, 0, 0, 0, S_DRN, C_BUB,  0, 0, "drain2_1");
    step(1, I_NOP, 0, 0, 0, 1, S_DRN, C_DRS,  0, 0, "drain2_frz");
    step(1, I_NOP, 0, 0, 0, 0, S_DRN, C_BUB,  0, 0, "drain2_3");
    step(1, I_NOP, 0, 0, 0, 0, S_DRN, C_BUB,  0, 0, "drain2_4");
    step(1, I_NOP, 0, 0, 0, 0, S_HLT, C_HLT,  0, 0, "halted_t5");
    // Reset in the middle of DRAIN, asserted between edges
    step(0, I_NOP, 0, 0, 0, 0, S_RUN, C_FRZ,  0, 0, "reset2");
    step(1, I_NOP, 0, 0, 0, 0, S_RUN, C_NORM, 0, 0, "run3");
    step(1, I_NOP, 0, 0, 0, 1, S_RUN, C_FRZ,  0, 0, "frz");
    step(1, I_HLT, 0, 0, 0, 0, S_RUN, C_BUB,  1, 1, "hlt3_t");
    step(1, I_NOP, 0, 0, 0, 0, S_DRN, C_BUB,  1, 1, "drain3_1");
    step(0, I_NOP, 0, 0, 0, 0, S_RUN, C_FRZ,  0, 0, "reset_mid_drain");
    step(1, I_NOP, 0, 0, 0, 0, S_RUN, C_NORM, 0, 0, "run_after_drain_reset");
    // Saturation: 4-bit counter sticks at 15 while the 16-bit one keeps counting
    for (int i = 0; i < 20; i++)
      step(1, I_NOP, 0, 0, 0, 1, S_RUN, C_FRZ, 16'(i), (i > 15) ? 4'd15 : 4'(i), "sat_frz");
    step(1, I_NOP, 0, 0, 0, 1, S_RUN, C_FRZ,  20, 15, "sat_hold");
    step(1, I_NOP, 0, 0, 0, 0, S_RUN, C_NORM, 21, 15, "sat_final");
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
